digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry_pkg.sv | 30 +++
 rtl/digit_entry_edge_cond.sv | 96 +++++++++
 rtl/digit_entry.sv | 107 ++++++++++
 tb/tb_digit_entry.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and defaults for the hex keypad digit-entry block.
package digit_entry_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLR,
    OP_BKSP,
    OP_KEY
  } op_t;

  localparam int unsigned DEFAULT_MAX_DIGITS = 8;

  // Lowest asserted key line wins.
  function automatic digit_t prio_enc(input logic [15:0] lines);
    digit_t code;
    logic   found;
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (lines[i] && !found) begin
        code  = digit_t'(i);
        found = 1'b1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/digit_entry_edge_cond.sv
// Input conditioner: two-flop synchronizer, optional debounce (DIGIT_ENTRY_DEBOUNCE_EN)
// and rising-edge event on the OR of the conditioned lines.
module edge_cond
  import digit_entry_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] vec,
  output logic             rise
);

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
    $error("edge_cond: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [1:0]       warm_q, warm_d;
  logic             prev_q, prev_d;
  logic             arm_q, arm_d;
  logic             level;

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNTW = $clog2(DEBOUNCE_CYCLES + 1);

  logic             lvl_q, lvl_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             sync_lvl;

  assign sync_lvl = |sync_q;

  // The lines are latched at the moment the level is accepted as high.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    cap_d = cap_q;
    if (sync_lvl != lvl_q) begin
      if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = sync_lvl;
        if (sync_lvl) cap_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= 1'b0;
      cnt_q <= '0;
      cap_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      cap_q <= cap_d;
    end
  end

  assign level = lvl_q;
  assign vec   = cap_q;
`else
  assign level = |sync_q;
  assign vec   = sync_q;
`endif

  // Events are only armed once the synchronizer has seen the input low after
  // reset, so a button held through reset must be released first.
  always_comb begin
    warm_d = {warm_q[0], 1'b1};
    prev_d = level;
    arm_d  = arm_q | (warm_q[1] & ~(|sync_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      warm_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      warm_q <= warm_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  assign rise = level & ~prev_q & arm_q;

endmodule

// File: rtl/digit_entry.sv
// Hex keypad digit-entry register with backspace and clear; debounce of the
// inputs is compiled in with DIGIT_ENTRY_DEBOUNCE_EN.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int unsigned MAX_DIGITS      = DEFAULT_MAX_DIGITS,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                               hz100,
  input  logic                               reset,
  input  logic [15:0]                        keys,
  input  logic                               bksp,
  input  logic                               clr,
  output logic [4*MAX_DIGITS-1:0]            digits,
  output logic [MAX_DIGITS-1:0]              digit_en,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    count,
  output logic                               full,
  output logic                               accept
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned DW = 4 * MAX_DIGITS;

  logic [15:0]   key_vec;
  logic          key_ev, bksp_ev, clr_ev;
  logic          unused_bksp_vec, unused_clr_vec;
  digit_t        key_code;
  op_t           op;
  logic          full_w;

  logic [DW-1:0] digits_q, digits_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept_q, accept_d;

  edge_cond #(.WIDTH(16), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_cond (
    .clk(hz100), .reset(reset), .din(keys), .vec(key_vec), .rise(key_ev)
  );

  edge_cond #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bksp_cond (
    .clk(hz100), .reset(reset), .din(bksp), .vec(unused_bksp_vec), .rise(bksp_ev)
  );

  edge_cond #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_cond (
    .clk(hz100), .reset(reset), .din(clr), .vec(unused_clr_vec), .rise(clr_ev)
  );

  assign key_code = prio_enc(key_vec);
  assign full_w   = (count_q == CW'(MAX_DIGITS));

  always_comb begin
    op = OP_NONE;
    if (clr_ev)       op = OP_CLR;
    else if (bksp_ev) op = OP_BKSP;
    else if (key_ev)  op = OP_KEY;
  end

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    accept_d = 1'b0;
    case (op)
      OP_CLR: begin
        digits_d = '0;
        count_d  = '0;
      end
      OP_BKSP: begin
        if (count_q != '0) begin
          digits_d = {4'h0, digits_q[DW-1:4]};
          count_d  = count_q - 1'b1;
        end
      end
      OP_KEY: begin
        if (!full_w) begin
          digits_d = {digits_q[DW-5:0], key_code};
          count_d  = count_q + 1'b1;
          accept_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      digits_q <= '0;
      count_q  <= '0;
      accept_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      accept_q <= accept_d;
    end
  end

  always_comb begin
    digit_en = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      digit_en[i] = (i < 32'(count_q));
    end
  end

  assign digits = digits_q;
  assign count  = count_q;
  assign full   = full_w;
  assign accept = accept_q;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: directed scenarios plus randomized
// key/backspace/clear traffic compared against a queue-based model.
module tb_digit_entry;
  import digit_entry_pkg::*;

  localparam int unsigned MAXD = 8;
  localparam int unsigned DBC  = 4;
  localparam int unsigned DW   = 4 * MAXD;
  localparam int unsigned CW   = $clog2(MAXD + 1);
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam int unsigned LAT = 3 + DBC;
`else
  localparam int unsigned LAT = 3;
`endif
  localparam int unsigned HOLD_MIN = LAT - 2;
  localparam int unsigned GAP_MIN  = LAT + 1;

  logic            hz100 = 1'b0;
  logic            reset;
  logic [15:0]     keys;
  logic            bksp, clr;
  logic [DW-1:0]   digits;
  logic [MAXD-1:0] digit_en;
  logic [CW-1:0]   count;
  logic            full, accept;

  int          checks = 0;
  int          fails  = 0;
  int unsigned acc_cnt = 0;
  digit_t      model_q[$];

  digit_entry #(.MAX_DIGITS(MAXD), .DEBOUNCE_CYCLES(DBC)) dut (
    .hz100(hz100), .reset(reset), .keys(keys), .bksp(bksp), .clr(clr),
    .digits(digits), .digit_en(digit_en), .count(count), .full(full), .accept(accept)
  );

  always #5 hz100 = ~hz100;

  always @(negedge hz100) if (accept === 1'b1) acc_cnt++;

  // Reference model: newest digit at the queue front.
  function automatic logic [DW-1:0] model_digits();
    logic [DW-1:0] v;
    v = '0;
    foreach (model_q[i]) v[4*i +: 4] = model_q[i];
    return v;
  endfunction

  function automatic logic [MAXD-1:0] model_en();
    logic [MAXD-1:0] e;
    e = '0;
    for (int unsigned i = 0; i < MAXD; i++) e[i] = (i < model_q.size());
    return e;
  endfunction

  task automatic model_key(input int unsigned k);
    if (model_q.size() < MAXD) model_q.push_front(digit_t'(k));
  endtask

  task automatic model_bksp();
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge hz100);
    #1;
  endtask

  task automatic press_keys(input logic [15:0] mask, input int unsigned hold, input int unsigned gap);
    keys = mask;
    cycles(hold);
    keys = '0;
    cycles(gap);
  endtask

  task automatic press_btn(input logic c, input logic b, input int unsigned hold, input int unsigned gap);
    clr  = c;
    bksp = b;
    cycles(hold);
    clr  = 1'b0;
    bksp = 1'b0;
    cycles(gap);
  endtask

  task automatic test_reset();
    reset = 1'b1; keys = '0; bksp = 1'b0; clr = 1'b0;
    cycles(3);
    checks++; if (digits !== '0) begin fails++; $display("FAIL reset_digits: got %h want 0", digits); end
    checks++; if (count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (digit_en !== '0) begin fails++; $display("FAIL reset_en: got %b want 0", digit_en); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (accept !== 1'b0) begin fails++; $display("FAIL reset_accept: got %b want 0", accept); end
    reset = 1'b0;
    model_q.delete();
    cycles(6);
  endtask

  task automatic test_two_keys();
    int unsigned base;
    base = acc_cnt;
    press_keys(16'h0020, HOLD_MIN, GAP_MIN); model_key(5);
    press_keys(16'h0400, HOLD_MIN, GAP_MIN); model_key(10);
    checks++; if (digits !== 32'h0000_005A) begin fails++; $display("FAIL two_keys_digits: got %h want 0000005a", digits); end
    checks++; if (count !== CW'(2)) begin fails++; $display("FAIL two_keys_count: got %0d want 2", count); end
    checks++; if (digit_en !== 8'b0000_0011) begin fails++; $display("FAIL two_keys_en: got %b want 00000011", digit_en); end
    checks++; if (acc_cnt - base !== 2) begin fails++; $display("FAIL two_keys_accepts: got %0d want 2", acc_cnt - base); end
  endtask

  task automatic test_latency();
    logic exp;
    press_btn(1'b1, 1'b0, HOLD_MIN, GAP_MIN); model_q.delete();
    keys = 16'h0010;
    for (int unsigned e = 1; e <= LAT + 1; e++) begin
      cycles(1);
      exp = (e == LAT);
      checks++; if (accept !== exp) begin fails++; $display("FAIL latency_accept[edge %0d]: got %b want %b", e, accept, exp); end
    end
    keys = '0;
    cycles(GAP_MIN);
    model_key(4);
    checks++; if (digits !== model_digits()) begin fails++; $display("FAIL latency_digits: got %h want %h", digits, model_digits()); end
  endtask

  task automatic test_fill();
    int unsigned base;
    press_btn(1'b1, 1'b0, HOLD_MIN, GAP_MIN); model_q.delete();
    base = acc_cnt;
    for (int unsigned k = 1; k <= 8; k++) press_keys(16'd1 << k, HOLD_MIN, GAP_MIN);
    checks++; if (acc_cnt - base !== 8) begin fails++; $display("FAIL fill_accepts: got %0d want 8", acc_cnt - base); end
    base = acc_cnt;
    press_keys(16'd1 << 9, HOLD_MIN, GAP_MIN);
    for (int unsigned k = 1; k <= 9; k++) model_key(k);
    checks++; if (acc_cnt - base !== 0) begin fails++; $display("FAIL fill_ninth_accept: got %0d want 0", acc_cnt - base); end
    checks++; if (digits !== 32'h1234_5678) begin fails++; $display("FAIL fill_digits: got %h want 12345678", digits); end
    checks++; if (count !== CW'(8)) begin fails++; $display("FAIL fill_count: got %0d want 8", count); end
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full); end
  endtask

  task automatic test_bksp();
    press_btn(1'b1, 1'b0, HOLD_MIN, GAP_MIN); model_q.delete();
    for (int unsigned k = 1; k <= 3; k++) begin press_keys(16'd1 << k, HOLD_MIN, GAP_MIN); model_key(k); end
    press_btn(1'b0, 1'b1, HOLD_MIN, GAP_MIN); model_bksp();
    checks++; if (digits !== 32'h0000_0012) begin fails++; $display("FAIL bksp_digits: got %h want 00000012", digits); end
    checks++; if (count !== CW'(2)) begin fails++; $display("FAIL bksp_count: got %0d want 2", count); end
    press_btn(1'b1, 1'b0, HOLD_MIN, GAP_MIN); model_q.delete();
    press_btn(1'b0, 1'b1, HOLD_MIN, GAP_MIN); model_bksp();
    checks++; if (digits !== '0 || count !== '0) begin fails++; $display("FAIL bksp_at_zero: got %h/%0d want 0/0", digits, count); end
  endtask

  task automatic test_simultaneous();
    int unsigned base;
    for (int unsigned k = 0; k < 3; k++) begin press_keys(16'd1 << (k + 2), HOLD_MIN, GAP_MIN); model_key(k + 2); end
    checks++; if (count !== CW'(3)) begin fails++; $display("FAIL simul_setup_count: got %0d want 3", count); end
    base = acc_cnt;
    keys = 16'h0080; clr = 1'b1; bksp = 1'b1;
    cycles(HOLD_MIN + 2);
    keys = '0; clr = 1'b0; bksp = 1'b0;
    cycles(GAP_MIN);
    model_q.delete();
    checks++; if (digits !== '0) begin fails++; $display("FAIL simul_digits: got %h want 0", digits); end
    checks++; if (count !== '0) begin fails++; $display("FAIL simul_count: got %0d want 0", count); end
    checks++; if (acc_cnt - base !== 0) begin fails++; $display("FAIL simul_accept: got %0d pulses want 0", acc_cnt - base); end
  endtask

  task automatic test_hold();
    int unsigned base;
    press_btn(1'b1, 1'b0, HOLD_MIN, GAP_MIN); model_q.delete();
    base = acc_cnt;
    keys = 16'h0008;
    cycles(20);
    keys = 16'h0208;
    cycles(LAT + 4);
    keys = 16'h0008;
    cycles(LAT + 4);
    keys = '0;
    cycles(GAP_MIN);
    model_key(3);
    checks++; if (acc_cnt - base !== 1) begin fails++; $display("FAIL hold_accepts: got %0d want 1", acc_cnt - base); end
    checks++; if (digits !== model_digits()) begin fails++; $display("FAIL hold_digits: got %h want %h", digits, model_digits()); end
    press_btn(1'b1, 1'b0, HOLD_MIN, GAP_MIN); model_q.delete();
    press_keys(16'h0208, HOLD_MIN, GAP_MIN); model_key(3);
    checks++; if (digits !== 32'h0000_0003) begin fails++; $display("FAIL prio_digits: got %h want 00000003", digits); end
  endtask

  task automatic test_reset_held();
    int unsigned base;
    keys = 16'h0040;
    cycles(3);
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    model_q.delete();
    base = acc_cnt;
    cycles(20);
    checks++; if (count !== '0 || acc_cnt - base !== 0) begin fails++; $display("FAIL held_reset: got count %0d pulses %0d want 0/0", count, acc_cnt - base); end
    keys = '0;
    cycles(GAP_MIN + 2);
    press_keys(16'h0040, HOLD_MIN, GAP_MIN); model_key(6);
    checks++; if (digits !== 32'h0000_0006 || count !== CW'(1)) begin fails++; $display("FAIL held_repress: got %h/%0d want 00000006/1", digits, count); end
  endtask

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  task automatic test_glitch();
    int unsigned base;
    base = acc_cnt;
    press_keys(16'h0002, 2, LAT + DBC);
    checks++; if (acc_cnt - base !== 0 || digits !== model_digits()) begin fails++; $display("FAIL glitch: got %0d pulses digits %h want 0 and %h", acc_cnt - base, digits, model_digits()); end
  endtask
`endif

  task automatic test_random();
    int unsigned r, a, b, hold, gap, base, exp_acc;
    for (int n = 0; n < 40; n++) begin
      r       = $urandom_range(0, 9);
      hold    = HOLD_MIN + $urandom_range(0, 4);
      gap     = GAP_MIN + $urandom_range(0, 3);
      base    = acc_cnt;
      exp_acc = 0;
      if (r == 0) begin
        press_btn(1'b1, 1'b0, hold, gap);
        model_q.delete();
      end else if (r <= 2) begin
        press_btn(1'b0, 1'b1, hold, gap);
        model_bksp();
      end else begin
        a = $urandom_range(0, 15);
        b = (r == 9) ? $urandom_range(0, 15) : a;
        if (model_q.size() < MAXD) exp_acc = 1;
        model_key(a < b ? a : b);
        press_keys((16'd1 << a) | (16'd1 << b), hold, gap);
      end
      checks++; if (digits !== model_digits()) begin fails++; $display("FAIL rand_digits[%0d]: got %h want %h", n, digits, model_digits()); end
      checks++; if (count !== CW'(model_q.size())) begin fails++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, count, model_q.size()); end
      checks++; if (full !== (model_q.size() == MAXD)) begin fails++; $display("FAIL rand_full[%0d]: got %b", n, full); end
      checks++; if (digit_en !== model_en()) begin fails++; $display("FAIL rand_en[%0d]: got %b want %b", n, digit_en, model_en()); end
      checks++; if (acc_cnt - base !== exp_acc) begin fails++; $display("FAIL rand_accept[%0d]: got %0d want %0d", n, acc_cnt - base, exp_acc); end
    end
  endtask

  initial begin
    test_reset();
    test_two_keys();
    test_latency();
    test_fill();
    test_bksp();
    test_simultaneous();
    test_hold();
    test_reset_held();
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    test_glitch();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
